// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: boot-loads IM, then fetches with stall and branch redirect
module ifetch_unit #(
    parameter int data_size    = 32,
    parameter int address_size = 10,
    parameter int im_start     = 'h80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [data_size-1:0]    load_data,
    input  logic                    load_last,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [address_size-1:0] branch_target,
    output logic [address_size-1:0] IM_address,
    output logic                    IM_read,
    output logic                    IM_write,
    output logic                    IM_enable,
    output logic [data_size-1:0]    IMin,
    output logic [address_size-1:0] if_pc,
    output logic                    if_valid,
    output logic                    loading,
    output logic [data_size-1:0]    fetch_count
);

    localparam logic [address_size-1:0] start_addr = address_size'(im_start);
    localparam logic [address_size-1:0] addr_one   = {{(address_size-1){1'b0}}, 1'b1};
    localparam logic [data_size-1:0]    count_one  = {{(data_size-1){1'b0}}, 1'b1};

    typedef enum logic {LOAD, FETCH} state_t;

    state_t                  state;
    logic [address_size-1:0] load_ptr;
    logic [address_size-1:0] pc;

    assign loading = (state == LOAD);

    // IM strobes are combinational so a branch redirects the read in the same cycle
    always_comb begin
        IM_address = load_ptr;
        IM_read    = 1'b0;
        IM_write   = 1'b0;
        IM_enable  = 1'b0;
        IMin       = '0;
        if (!rst) begin
            if (state == LOAD) begin
                IM_enable = load_valid;
                IM_write  = load_valid;
                IMin      = load_data;
            end else if (branch_taken) begin
                IM_enable  = 1'b1;
                IM_read    = 1'b1;
                IM_address = branch_target;
            end else begin
                IM_address = pc;
                IM_enable  = !stall;
                IM_read    = !stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_ptr    <= start_addr;
            pc          <= start_addr;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_valid) begin
                        load_ptr <= load_ptr + addr_one;
                        if (load_last) begin
                            state <= FETCH;
                            pc    <= start_addr;
                        end
                    end
                end
                FETCH: begin
                    if (branch_taken) begin
                        if_pc       <= branch_target;
                        if_valid    <= 1'b1;
                        pc          <= branch_target + addr_one;
                        fetch_count <= fetch_count + count_one;
                    end else if (!stall) begin
                        if_pc       <= pc;
                        if_valid    <= 1'b1;
                        pc          <= pc + addr_one;
                        fetch_count <= fetch_count + count_one;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed bench for ifetch_unit with behavioural IM models
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = '0;

    logic [9:0]  IM_address, if_pc;
    logic        IM_read, IM_write, IM_enable, if_valid, loading;
    logic [31:0] IMin, fetch_count;

    logic [9:0]  IM_address_w, if_pc_w;
    logic        IM_read_w, IM_write_w, IM_enable_w, if_valid_w, loading_w;
    logic [31:0] IMin_w, fetch_count_w;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_w [1024];
    logic [31:0] dout_a, dout_w;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .IM_address(IM_address), .IM_read(IM_read),
        .IM_write(IM_write), .IM_enable(IM_enable), .IMin(IMin), .if_pc(if_pc),
        .if_valid(if_valid), .loading(loading), .fetch_count(fetch_count)
    );

    ifetch_unit #(.im_start(1020)) dut_w (
        .clk(clk), .rst(rst_w), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(10'd0), .IM_address(IM_address_w), .IM_read(IM_read_w),
        .IM_write(IM_write_w), .IM_enable(IM_enable_w), .IMin(IMin_w), .if_pc(if_pc_w),
        .if_valid(if_valid_w), .loading(loading_w), .fetch_count(fetch_count_w)
    );

    // IM: cleared by rst, 1-cycle read latency, output holds when not enabled
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
            dout_a <= '0;
        end else if (IM_enable) begin
            if (IM_write) mem_a[IM_address] <= IMin;
            if (IM_read) dout_a <= mem_a[IM_address];
        end
    end

    always @(posedge clk) begin
        if (rst_w) begin
            for (int j = 0; j < 1024; j++) mem_w[j] <= '0;
            dout_w <= '0;
        end else if (IM_enable_w) begin
            if (IM_write_w) mem_w[IM_address_w] <= IMin_w;
            if (IM_read_w) dout_w <= mem_w[IM_address_w];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        load_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++; if (IM_enable !== 1'b0) begin failed++; $display("FAIL rst_enable cyc%0d got %b exp 0", c, IM_enable); end
            tests++; if (IM_write !== 1'b0) begin failed++; $display("FAIL rst_write cyc%0d got %b exp 0", c, IM_write); end
        end
        rst = 1'b0;
        load_valid = 1'b0;
        #1;
        tests++; if (loading !== 1'b1) begin failed++; $display("FAIL idle_loading got %b exp 1", loading); end
        tests++; if (IM_enable !== 1'b0) begin failed++; $display("FAIL idle_enable got %b exp 0", IM_enable); end
        tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL idle_valid got %b exp 0", if_valid); end
        tests++; if (fetch_count !== 32'd0) begin failed++; $display("FAIL idle_count got %0d exp 0", fetch_count); end
    endtask

    task automatic test_load;
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1;
            load_data  = words[k];
            load_last  = (k == 3);
            #1;
            tests++; if (IM_address !== 10'(10'h80 + k)) begin failed++; $display("FAIL load_addr %0d got %h exp %h", k, IM_address, 10'h80 + k); end
            tests++; if ({IM_enable, IM_write, IM_read} !== 3'b110) begin failed++; $display("FAIL load_strobes %0d got %b exp 110", k, {IM_enable, IM_write, IM_read}); end
            tests++; if (IMin !== words[k]) begin failed++; $display("FAIL load_data %0d got %h exp %h", k, IMin, words[k]); end
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        tests++; if (loading !== 1'b0) begin failed++; $display("FAIL fetch_entry_loading got %b exp 0", loading); end
        tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL fetch_entry_valid got %b exp 0", if_valid); end
        tests++; if (IM_read !== 1'b1 || IM_address !== 10'h80) begin failed++; $display("FAIL fetch_entry_issue got rd=%b addr=%h exp rd=1 addr=080", IM_read, IM_address); end
    endtask

    task automatic test_fetch;
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            tests++; if (IM_address !== 10'(10'h80 + k)) begin failed++; $display("FAIL seq_issue %0d got %h exp %h", k, IM_address, 10'h80 + k); end
            step();
            tests++; if (if_pc !== 10'(10'h80 + k) || if_valid !== 1'b1) begin failed++; $display("FAIL seq_tag %0d got pc=%h v=%b exp pc=%h v=1", k, if_pc, if_valid, 10'h80 + k); end
            tests++; if (dout_a !== words[k]) begin failed++; $display("FAIL seq_word %0d got %h exp %h", k, dout_a, words[k]); end
            tests++; if (fetch_count !== 32'(k + 1)) begin failed++; $display("FAIL seq_count %0d got %0d exp %0d", k, fetch_count, k + 1); end
        end
        // redirect back to 'h81 so the stall scenario starts from if_pc='h81
        branch_taken  = 1'b1;
        branch_target = 10'h81;
        #1;
        tests++; if (IM_address !== 10'h81) begin failed++; $display("FAIL redirect_addr got %h exp 081", IM_address); end
        step();
        branch_taken = 1'b0;
        tests++; if (if_pc !== 10'h81 || dout_a !== 32'h22 || fetch_count !== 32'd5) begin failed++; $display("FAIL redirect_tag got pc=%h d=%h n=%0d exp 081 22 5", if_pc, dout_a, fetch_count); end
    endtask

    task automatic test_stall;
        for (int c = 0; c < 3; c++) begin
            stall = 1'b1;
            #1;
            tests++; if (IM_enable !== 1'b0 || IM_read !== 1'b0) begin failed++; $display("FAIL stall_strobe %0d got en=%b rd=%b exp 0 0", c, IM_enable, IM_read); end
            step();
            tests++; if (if_pc !== 10'h81 || if_valid !== 1'b1 || dout_a !== 32'h22 || fetch_count !== 32'd5) begin failed++; $display("FAIL stall_hold %0d got pc=%h v=%b d=%h n=%0d exp 081 1 22 5", c, if_pc, if_valid, dout_a, fetch_count); end
        end
        stall = 1'b0;
        #1;
        tests++; if (IM_address !== 10'h82 || IM_enable !== 1'b1) begin failed++; $display("FAIL stall_resume_issue got addr=%h en=%b exp 082 1", IM_address, IM_enable); end
        step();
        tests++; if (if_pc !== 10'h82 || dout_a !== 32'h33 || fetch_count !== 32'd6) begin failed++; $display("FAIL stall_resume_tag got pc=%h d=%h n=%0d exp 082 33 6", if_pc, dout_a, fetch_count); end
    endtask

    task automatic test_branch;
        branch_taken  = 1'b1;
        branch_target = 10'h80;
        stall         = 1'b1;
        #1;
        tests++; if (IM_address !== 10'h80 || IM_read !== 1'b1 || IM_enable !== 1'b1) begin failed++; $display("FAIL branch_issue got addr=%h rd=%b en=%b exp 080 1 1", IM_address, IM_read, IM_enable); end
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        #1;
        tests++; if (if_pc !== 10'h80 || if_valid !== 1'b1 || dout_a !== 32'h11) begin failed++; $display("FAIL branch_tag got pc=%h v=%b d=%h exp 080 1 11", if_pc, if_valid, dout_a); end
        tests++; if (fetch_count !== 32'd7) begin failed++; $display("FAIL branch_count got %0d exp 7", fetch_count); end
        tests++; if (IM_address !== 10'h81) begin failed++; $display("FAIL branch_next_pc got %h exp 081", IM_address); end
    endtask

    task automatic test_reset_mid_fetch;
        step();
        step();
        tests++; if (if_pc !== 10'h82) begin failed++; $display("FAIL mid_setup got %h exp 082", if_pc); end
        rst = 1'b1;
        #1;
        tests++; if (IM_enable !== 1'b0 || IM_read !== 1'b0) begin failed++; $display("FAIL mid_rst_strobe got en=%b rd=%b exp 0 0", IM_enable, IM_read); end
        step();
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h99;
        load_last  = 1'b1;
        #1;
        tests++; if (loading !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd0) begin failed++; $display("FAIL mid_rst_state got ld=%b v=%b n=%0d exp 1 0 0", loading, if_valid, fetch_count); end
        tests++; if (IM_address !== 10'h80 || IM_write !== 1'b1) begin failed++; $display("FAIL reload_write got addr=%h wr=%b exp 080 1", IM_address, IM_write); end
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        tests++; if (loading !== 1'b0 || IM_address !== 10'h80) begin failed++; $display("FAIL reload_fetch got ld=%b addr=%h exp 0 080", loading, IM_address); end
        step();
        tests++; if (if_pc !== 10'h80 || dout_a !== 32'h99 || if_valid !== 1'b1) begin failed++; $display("FAIL reload_tag got pc=%h d=%h v=%b exp 080 99 1", if_pc, dout_a, if_valid); end
        step();
        tests++; if (if_pc !== 10'h81 || dout_a !== 32'h0) begin failed++; $display("FAIL reload_cleared got pc=%h d=%h exp 081 0", if_pc, dout_a); end
    endtask

    task automatic test_wrap;
        logic [9:0] addrs [6];
        addrs[0] = 10'd1020; addrs[1] = 10'd1021; addrs[2] = 10'd1022;
        addrs[3] = 10'd1023; addrs[4] = 10'd0;    addrs[5] = 10'd1;
        rst_w = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load_valid = 1'b1;
            load_data  = 32'hA0 + k;
            load_last  = (k == 5);
            #1;
            tests++; if (IM_address_w !== addrs[k] || IM_write_w !== 1'b1) begin failed++; $display("FAIL wrap_write %0d got addr=%0d wr=%b exp %0d 1", k, IM_address_w, IM_write_w, addrs[k]); end
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        tests++; if (IM_address_w !== 10'd1020 || loading_w !== 1'b0) begin failed++; $display("FAIL wrap_entry got addr=%0d ld=%b exp 1020 0", IM_address_w, loading_w); end
        for (int k = 0; k < 6; k++) begin
            step();
            tests++; if (if_pc_w !== addrs[k] || if_valid_w !== 1'b1) begin failed++; $display("FAIL wrap_tag %0d got pc=%0d v=%b exp %0d 1", k, if_pc_w, if_valid_w, addrs[k]); end
            tests++; if (dout_w !== 32'hA0 + k) begin failed++; $display("FAIL wrap_word %0d got %h exp %h", k, dout_w, 32'hA0 + k); end
        end
        tests++; if (fetch_count_w !== 32'd6) begin failed++; $display("FAIL wrap_count got %0d exp 6", fetch_count_w); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_stall();
        test_branch();
        test_reset_mid_fetch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of the instruction memory (IM) and drives its full port set.
- After reset it runs a boot-load phase: a word stream is written sequentially into IM starting at im_start.
- It then fetches sequentially from im_start, with stall and zero-bubble branch redirect.
- It tags every instruction appearing on the IM instruction output with its address and a valid bit for decode.

Parameters:
data_size, 32, instruction/data word width
address_size, 10, IM word-address width; all PC arithmetic is modulo 2**address_size
im_start, 'h80, first program word address; load base and fetch start PC

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset; same net as IM rst
load_valid  in  1  load word present (sampled only in LOAD)
load_data  in  data_size  program word to write
load_last  in  1  qualifies load_valid: this is the final program word
stall  in  1  hold fetch; IM output and tags frozen
branch_taken  in  1  redirect fetch this cycle
branch_target  in  address_size  redirect address
IM_address  out  address_size  IM word address
IM_read  out  1  IM read strobe
IM_write  out  1  IM write strobe
IM_enable  out  1  IM enable
IMin  out  data_size  IM write data
if_pc  out  address_size  address of the word now on IM instruction output
if_valid  out  1  IM instruction output is a live fetched word
loading  out  1  high while in LOAD
fetch_count  out  data_size  count of words delivered (wraps)

Behaviour:
- States: LOAD, FETCH. rst -> LOAD regardless of current state, including mid-load or mid-fetch. Registers on reset: load_ptr=im_start, pc=im_start, if_pc=0, if_valid=0, fetch_count=0.
- IM clears its memory on the same rst, so a reset always requires a full reload.
- During the rst cycle, IM_enable, IM_read and IM_write are 0.
- LOAD state (loading=1; the IM strobes below are combinational from state and inputs):
  - IM_read=0. IM_enable=IM_write=load_valid. IM_address=load_ptr. IMin=load_data.
  - On each edge with load_valid=1: load_ptr<=load_ptr+1, wrapping mod 2**address_size.
  - load_valid=1 with load_last=1: that word is written, then state<=FETCH and pc<=im_start.
  - load_last without load_valid is ignored.
  - A one-word program is legal.
- FETCH state (loading=0). IM_write=0; IMin is don't-care and driven 0. Priority order: branch_taken > stall > sequential.
  - branch_taken=1: IM_enable=IM_read=1, IM_address=branch_target (combinational mux). At the edge: if_pc<=branch_target, if_valid<=1, pc<=branch_target+1. Stall is ignored.
  - stall=1 (no branch): IM_enable=0, IM_read=0. pc, if_pc, if_valid and fetch_count hold. IM instruction output holds by IM's own semantics.
  - Otherwise: IM_enable=IM_read=1, IM_address=pc. At the edge: if_pc<=pc, if_valid<=1, pc<=pc+1 (wrap).
- Read latency: 1 cycle. The word for an address issued in cycle N appears on IM instruction output in cycle N+1, together with if_pc=that address and if_valid=1.
- fetch_count increments by 1 on every FETCH edge that issues a read (sequential or branch). It wraps at 2**data_size.
- if_valid stays 0 throughout LOAD and for the first FETCH cycle (no read has completed yet).
- PC wrap: pc=2**address_size-1 is followed by pc=0. No trap is raised.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release -> loading=1, IM_enable=0, if_valid=0, fetch_count=0.
- Load 4 words 0x11,0x22,0x33,0x44 (last on 0x44), then run unstalled -> IM writes at 'h80..'h83. Fetch issues 'h80 on the cycle after the last write. if_pc='h80 with instruction 0x11 one cycle later, then 0x22, 0x33, 0x44 on consecutive cycles. fetch_count=4 after four issues.
- Stall for 3 cycles while if_pc='h81 -> IM_enable=0; if_pc='h81, instruction 0x22 and fetch_count are frozen. Sequence resumes at 'h82 after the stall drops.
- branch_taken=1, target='h80, asserted together with stall=1 while issuing 'h83 -> IM_address='h80 that cycle. Next cycle if_pc='h80 with 0x11, and pc='h81 (no bubble, stall ignored).
- Wrap: load a program with im_start=1020 and 6 words -> writes go to 1020..1023,0,1. Fetch if_pc sequence is 1020,1021,1022,1023,0,1.
- rst mid-fetch (if_pc='h82) -> next cycle loading=1, if_valid=0, pc=im_start. A reload of 1 word with load_last=1 re-enters FETCH at 'h80.
